reg_bank_32: RTL and testbench

- Storage stage of the register file: 32 registers of WIDTH bits with one synchronous write port.
- Drives all 32 register values, as a flattened bus, into the two downstream 32:1 read multiplexers (ports A and B).
- Adds a per-register "written since reset" valid bit and a registered write-acknowledge pulse for pipeline/verification visibility.

---
 rtl/reg_file_pkg.sv | 10 +
 rtl/decoder_5to32.sv | 17 +
 rtl/reg_bank_32.sv | 90 +++++++++
 tb/tb_reg_bank_32.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the register-file storage stage.
package reg_file_pkg;
    localparam int          NUM_REGS = 32;
    localparam int          ADDR_W   = 5;
    localparam int          ZERO_IDX = 0;
    localparam int          CNT_W    = 16;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/decoder_5to32.sv
// One-hot write-select decoder: sel_o[k] is set only when en_i is high and addr_i == k.
module decoder_5to32
    import reg_file_pkg::*;
(
    input  logic                en_i,
    input  addr_t               addr_i,
    output logic [NUM_REGS-1:0] sel_o
);

    always_comb begin
        sel_o = '0;
        if (en_i) begin
            sel_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_32.sv
// 32-entry register storage with one synchronous write port, sticky valid bits,
// write-ack pulse and saturating write counter. Optional macro: ZERO_REG_EN (hardwired zero register).
module reg_bank_32
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      Wr_En,
    input  addr_t                     Wr_Addr,
    input  logic [WIDTH-1:0]          Wr_Data,
    output logic [NUM_REGS*WIDTH-1:0] Reg_Flat,
    output logic [NUM_REGS-1:0]       Valid,
    output logic                      Wr_Ack,
    output logic [CNT_W-1:0]          Wr_Count
);

`ifdef ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic [NUM_REGS-1:0] sel;
    logic                ack_q, ack_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    decoder_5to32 u_dec (
        .en_i   (Wr_En),
        .addr_i (Wr_Addr),
        .sel_o  (sel)
    );

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        if (ZERO_EN && (k == ZERO_IDX)) begin : g_zero
            // Hardwired entry: writes are still acknowledged and counted, just not stored.
            assign Reg_Flat[k*WIDTH +: WIDTH] = '0;
            assign Valid[k]                   = 1'b1;
        end else begin : g_store
            logic [WIDTH-1:0] data_q, data_d;
            logic             vld_q, vld_d;

            always_comb begin
                data_d = data_q;
                vld_d  = vld_q;
                if (sel[k]) begin
                    data_d = Wr_Data;
                    vld_d  = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    data_q <= data_d;
                    vld_q  <= vld_d;
                end
            end

            assign Reg_Flat[k*WIDTH +: WIDTH] = data_q;
            assign Valid[k]                   = vld_q;
        end
    end

    always_comb begin
        ack_d = Wr_En;
        cnt_d = cnt_q;
        if (Wr_En && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ack_q <= ack_d;
            cnt_q <= cnt_d;
        end
    end

    assign Wr_Ack   = ack_q;
    assign Wr_Count = cnt_q;

endmodule

// File: tb/tb_reg_bank_32.sv
// Scoreboard bench for reg_bank_32: stimulus pushes expected state, a negedge monitor pops and compares.
module tb_reg_bank_32;
    localparam int WIDTH = 32;
    localparam int NR    = 32;

`ifdef ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic                clk;
    logic                reset;
    logic                Wr_En;
    logic [4:0]          Wr_Addr;
    logic [WIDTH-1:0]    Wr_Data;
    logic [NR*WIDTH-1:0] Reg_Flat;
    logic [NR-1:0]       Valid;
    logic                Wr_Ack;
    logic [15:0]         Wr_Count;

    reg_bank_32 #(.WIDTH(WIDTH), .NUM_REGS(NR)) dut (
        .clk      (clk),
        .reset    (reset),
        .Wr_En    (Wr_En),
        .Wr_Addr  (Wr_Addr),
        .Wr_Data  (Wr_Data),
        .Reg_Flat (Reg_Flat),
        .Valid    (Valid),
        .Wr_Ack   (Wr_Ack),
        .Wr_Count (Wr_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NR*WIDTH-1:0] flat;
        logic [NR-1:0]       valid;
        logic                ack;
        logic [15:0]         cnt;
        string               name;
    } exp_t;

    exp_t exp_q[$];

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    logic [WIDTH-1:0] m_regs [NR];
    logic [NR-1:0]    m_valid;
    logic             m_ack;
    logic [15:0]      m_cnt;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_valid = ZERO_EN ? 32'h1 : 32'h0;
        m_ack   = 1'b0;
        m_cnt   = 16'h0;
    endtask

    task automatic push_exp(input string name);
        exp_t e;
        for (int i = 0; i < NR; i++) e.flat[i*WIDTH +: WIDTH] = m_regs[i];
        e.valid = m_valid;
        e.ack   = m_ack;
        e.cnt   = m_cnt;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    // Apply one cycle of inputs, advance the model at the edge, optionally queue a check.
    task automatic step(input bit rst, input bit en, input logic [4:0] addr,
                        input logic [WIDTH-1:0] data, input bit chk, input string name);
        reset   = rst;
        Wr_En   = en;
        Wr_Addr = addr;
        Wr_Data = data;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (en) begin
            if (!(ZERO_EN && addr == 5'd0)) begin
                m_regs[addr]  = data;
                m_valid[addr] = 1'b1;
            end
            m_ack = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
        end else begin
            m_ack = 1'b0;
        end
        if (chk) push_exp(name);
        #1;
    endtask

    task automatic idle(input bit chk, input string name);
        step(1'b0, 1'b0, 5'd0, '0, chk, name);
    endtask

    // Monitor: outputs are presented every cycle; compare against any pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (Reg_Flat !== e.flat) begin
                    n_fail++;
                    for (int k = 0; k < NR; k++) begin
                        if (Reg_Flat[k*WIDTH +: WIDTH] !== e.flat[k*WIDTH +: WIDTH]) begin
                            $display("FAIL %s reg[%0d]: got %h expected %h", e.name, k,
                                     Reg_Flat[k*WIDTH +: WIDTH], e.flat[k*WIDTH +: WIDTH]);
                            break;
                        end
                    end
                end
                n_vec++;
                if (Valid !== e.valid) begin
                    n_fail++;
                    $display("FAIL %s Valid: got %h expected %h", e.name, Valid, e.valid);
                end
                n_vec++;
                if (Wr_Ack !== e.ack) begin
                    n_fail++;
                    $display("FAIL %s Wr_Ack: got %b expected %b", e.name, Wr_Ack, e.ack);
                end
                n_vec++;
                if (Wr_Count !== e.cnt) begin
                    n_fail++;
                    $display("FAIL %s Wr_Count: got %h expected %h", e.name, Wr_Count, e.cnt);
                end
            end
        end
    end

    initial begin
        int guard;
        model_reset();
        reset   = 1'b1;
        Wr_En   = 1'b0;
        Wr_Addr = '0;
        Wr_Data = '0;

        // 1: reset then idle
        step(1'b1, 1'b0, 5'd0, '0, 1'b1, "reset");
        step(1'b1, 1'b0, 5'd0, '0, 1'b0, "reset");
        for (int i = 0; i < 3; i++) idle(1'b1, "idle_after_reset");

        // 2: single write, one-cycle ack
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, "write5");
        idle(1'b1, "write5_ack_drop");
        idle(1'b1, "write5_hold");

        // 3: back-to-back same address
        step(1'b0, 1'b1, 5'd7, 32'h1, 1'b1, "b2b_1");
        step(1'b0, 1'b1, 5'd7, 32'h2, 1'b1, "b2b_2");
        step(1'b0, 1'b1, 5'd7, 32'h3, 1'b1, "b2b_3");
        idle(1'b1, "b2b_end");

        // 4: address 0
        step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, "write0");
        idle(1'b1, "write0_hold");

        // 5: fill all, then reset with a concurrent write
        for (int i = 0; i < NR; i++)
            step(1'b0, 1'b1, 5'(i), 32'(i * 3), (i == NR - 1), "fill");
        idle(1'b1, "fill_hold");
        step(1'b1, 1'b1, 5'd9, 32'hAA, 1'b1, "reset_with_write");
        idle(1'b1, "post_reset_idle");
        step(1'b0, 1'b1, 5'd9, 32'h55, 1'b1, "first_write_after_reset");
        idle(1'b1, "first_write_hold");

        // 6: saturate the counter
        while (m_cnt != 16'hFFFE)
            step(1'b0, 1'b1, 5'(m_cnt[4:0]), 32'(m_cnt), 1'b0, "sat_fill");
        idle(1'b1, "cnt_fffe");
        step(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, "sat_w1");
        step(1'b0, 1'b1, 5'd4, 32'h22, 1'b1, "sat_w2");
        step(1'b0, 1'b1, 5'd6, 32'h33, 1'b1, "sat_w3");
        idle(1'b1, "sat_hold");

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
